sdr_burst_reader: RTL and testbench

SDR_BURST_READER -- requirements
Module: sdr_burst_reader

---
 rtl/sdr_pkg.sv | 15 +
 rtl/sdr_burst_reader.sv | 152 +++++++++++++++
 tb/tb_sdr_burst_reader.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdr_pkg.sv
// Shared widths, default sizing and FSM state type for the SDR burst reader.
package sdr_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned DEF_MAX_WORDS   = 64;
  localparam int unsigned DEF_MAX_PENDING = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sdr_burst_reader.sv
// Burst reader: fetches up to MAX_WORDS consecutive 32-bit words over an
// Avalon-MM master port into a flat result register, with bounded outstanding reads.
module sdr_burst_reader
  import sdr_pkg::*;
#(
  parameter int unsigned MAX_WORDS   = DEF_MAX_WORDS,
  parameter int unsigned MAX_PENDING = DEF_MAX_PENDING
) (
  input  logic                        sdr_clk,
  input  logic                        sdr_reset,
  input  logic                        readstart,
  input  logic [31:0]                 baseaddr,
  input  logic [29:0]                 nelems,
  output logic [WORD_W*MAX_WORDS-1:0] readdata,
  output logic                        readend,
  output logic                        busy,
  output logic                        err,
  output logic [31:0]                 avm_address,
  output logic                        avm_read,
  input  logic                        avm_waitrequest,
  input  logic [31:0]                 avm_readdata,
  input  logic                        avm_readdatavalid
);

  localparam int unsigned CNT_W  = $clog2(MAX_WORDS) + 1;
  localparam int unsigned IDX_W  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

  state_e                              state_q, state_d;
  logic [31:0]                         base_q, base_d;
  logic [CNT_W-1:0]                    n_q, n_d;
  logic [CNT_W-1:0]                    issued_q, issued_d;
  logic [CNT_W-1:0]                    received_q, received_d;
  logic [PEND_W-1:0]                   pending_q, pending_d;
  logic [MAX_WORDS-1:0][WORD_W-1:0]    data_q, data_d;
  logic                                err_q, err_d;
  logic                                readend_q, readend_d;
  logic                                busy_q, busy_d;
  logic                                avm_read_q, avm_read_d;
  logic [31:0]                         avm_address_q, avm_address_d;

  logic accept_c;
  logic active_c;
  logic rvalid_c;

  // A read is taken by the slave only when presented and not stalled.
  assign accept_c = avm_read_q & ~avm_waitrequest;
  assign active_c = (state_q == ISSUE) || (state_q == DRAIN);
  // Data beats count only while a transfer is live and something is actually owed.
  assign rvalid_c = avm_readdatavalid && active_c && (received_q < n_q) &&
                    ((pending_q != '0) || accept_c);

  // State, counters and registered outputs.
  always_ff @(posedge sdr_clk or posedge sdr_reset) begin
    if (sdr_reset) begin
      state_q       <= IDLE;
      base_q        <= '0;
      n_q           <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      pending_q     <= '0;
      data_q        <= '0;
      err_q         <= 1'b0;
      readend_q     <= 1'b0;
      busy_q        <= 1'b0;
      avm_read_q    <= 1'b0;
      avm_address_q <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      n_q           <= n_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      pending_q     <= pending_d;
      data_q        <= data_d;
      err_q         <= err_d;
      readend_q     <= readend_d;
      busy_q        <= busy_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
    end
  end

  // Next-state, counter updates and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    n_d        = n_q;
    issued_d   = issued_q;
    received_d = received_q;
    pending_d  = pending_q;
    data_d     = data_q;
    err_d      = err_q;

    if (accept_c) begin
      issued_d = issued_q + CNT_W'(1);
    end
    if (rvalid_c) begin
      data_d[received_q[IDX_W-1:0]] = avm_readdata;
      received_d = received_q + CNT_W'(1);
    end
    unique case ({accept_c, rvalid_c})
      2'b10:   pending_d = pending_q + PEND_W'(1);
      2'b01:   pending_d = pending_q - PEND_W'(1);
      default: pending_d = pending_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (readstart) begin
          base_d     = baseaddr & 32'hFFFF_FFFC;
          err_d      = ({2'b00, nelems} > 32'(MAX_WORDS));
          n_d        = err_d ? CNT_W'(MAX_WORDS) : CNT_W'(nelems);
          issued_d   = '0;
          received_d = '0;
          pending_d  = '0;
          data_d     = '0;
          // An empty request still passes through ISSUE so completion stays at n+2.
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (issued_d == n_q) begin
          state_d = (received_d == n_q) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (received_d == n_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    readend_d     = (state_d == DONE);
    busy_d        = (state_d != IDLE);
    avm_read_d    = (state_d == ISSUE) && (issued_d < n_d) &&
                    (pending_d < PEND_W'(MAX_PENDING));
    avm_address_d = base_d + (32'(issued_d) << 2);
  end

  assign readdata    = data_q;
  assign readend     = readend_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;

endmodule

// File: tb/tb_sdr_burst_reader.sv
// Self-checking bench for sdr_burst_reader with a randomly stalling,
// fixed-latency Avalon slave and a word-level expected-result model.
module tb_sdr_burst_reader;

  localparam int MAXW = 64;
  localparam int MAXP = 8;

  logic              sdr_clk;
  logic              sdr_reset;
  logic              readstart;
  logic [31:0]       baseaddr;
  logic [29:0]       nelems;
  logic [32*MAXW-1:0] readdata;
  logic              readend;
  logic              busy;
  logic              err;
  logic [31:0]       avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;

  sdr_burst_reader dut (
    .sdr_clk           (sdr_clk),
    .sdr_reset         (sdr_reset),
    .readstart         (readstart),
    .baseaddr          (baseaddr),
    .nelems            (nelems),
    .readdata          (readdata),
    .readend           (readend),
    .busy              (busy),
    .err               (err),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  initial sdr_clk = 1'b0;
  always #5 sdr_clk = ~sdr_clk;

  int checks = 0;
  int errors = 0;

  // Slave configuration and observations.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } rd_t;

  rd_t         rq[$];
  logic [31:0] acc_q[$];
  int          wait_pct = 0;
  int          lat = 1;
  int          cyc = 0;
  int          valids = 0;
  int          max_out = 0;
  int          stall_viol = 0;
  bit          stray_req = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Avalon slave: in-order returns after 'lat' cycles, random stalls, stall monitor.
  initial begin
    rd_t         it;
    bit          prev_stall;
    logic [31:0] prev_addr;
    prev_stall = 0;
    prev_addr = '0;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    forever begin
      @(negedge sdr_clk);
      cyc++;
      if (prev_stall && (!avm_read || avm_address != prev_addr)) stall_viol++;
      avm_readdatavalid = 1'b0;
      avm_readdata = '0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        it = rq.pop_front();
        avm_readdatavalid = 1'b1;
        avm_readdata = mem(it.addr);
        valids++;
      end else if (stray_req) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = 32'hDEAD_BEEF;
        stray_req = 0;
      end
      avm_waitrequest = ($urandom_range(99) < wait_pct);
      if (avm_read && !avm_waitrequest) begin
        it.addr = avm_address;
        it.due = cyc + lat;
        rq.push_back(it);
        acc_q.push_back(avm_address);
      end
      if (rq.size() > max_out) max_out = rq.size();
      prev_stall = avm_read && avm_waitrequest;
      prev_addr = avm_address;
    end
  end

  function automatic int nz_words();
    int c = 0;
    for (int i = 0; i < MAXW; i++) if (readdata[32*i +: 32] != 32'h0) c++;
    return c;
  endfunction

  // Compare every result word against the model: slave data for i<n, zero above.
  task automatic chk_readdata(input string nm, input logic [31:0] b, input int n);
    int bad = 0;
    int first = -1;
    logic [31:0] e;
    logic [31:0] a;
    logic [31:0] fe = '0;
    logic [31:0] fa = '0;
    for (int i = 0; i < MAXW; i++) begin
      e = (i < n) ? mem(b + 32'(4 * i)) : 32'h0;
      a = readdata[32*i +: 32];
      if (a !== e) begin
        bad++;
        if (first < 0) begin first = i; fe = e; fa = a; end
      end
    end
    chk($sformatf("%s word%0d (%0d bad words)", nm, first, bad), bad == 0, longint'(fa), longint'(fe));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_readdata_nz"}, nz_words() == 0, nz_words(), 0);
    chk({tag, "_readend"}, readend === 1'b0, readend, 0);
    chk({tag, "_busy"}, busy === 1'b0, busy, 0);
    chk({tag, "_err"}, err === 1'b0, err, 0);
    chk({tag, "_avm_read"}, avm_read === 1'b0, avm_read, 0);
    chk({tag, "_avm_address"}, avm_address === 32'h0, avm_address, 0);
  endtask

  // One request from pulse to completion; exp_end=0 skips the exact latency check.
  task automatic run_txn(input string nm, input logic [31:0] base, input logic [29:0] ne,
                         input int wp, input int lt, input int exp_reads, input bit exp_err,
                         input int exp_end);
    int t_end = -1;
    int t_first = -1;
    int abad = 0;
    logic [31:0] eb;
    eb = base & 32'hFFFF_FFFC;
    wait_pct = wp;
    lat = lt;
    acc_q.delete();
    max_out = 0;
    stall_viol = 0;
    @(posedge sdr_clk); #1;
    readstart = 1'b1; baseaddr = base; nelems = ne;
    @(posedge sdr_clk); #1;
    readstart = 1'b0; baseaddr = $urandom; nelems = 30'($urandom);
    for (int t = 1; t <= 3000; t++) begin
      @(negedge sdr_clk);
      if (t == 1) chk({nm, "_busy_c1"}, busy === 1'b1, busy, 1);
      if (avm_read && t_first < 0) t_first = t;
      if (readend) begin t_end = t; break; end
    end
    chk({nm, "_readend_seen"}, t_end > 0, t_end, exp_end);
    if (exp_end > 0) chk({nm, "_readend_cycle"}, t_end == exp_end, t_end, exp_end);
    if (exp_reads > 0) chk({nm, "_first_read_cycle"}, t_first == 1, t_first, 1);
    else chk({nm, "_no_read"}, t_first < 0, t_first, -1);
    chk({nm, "_err"}, err === exp_err, err, exp_err);
    chk_readdata({nm, "_readdata"}, eb, exp_reads);
    chk({nm, "_num_reads"}, acc_q.size() == exp_reads, acc_q.size(), exp_reads);
    for (int i = 0; i < acc_q.size(); i++) if (acc_q[i] != eb + 32'(4 * i)) abad++;
    chk({nm, "_addr_seq_bad"}, abad == 0, abad, 0);
    chk({nm, "_max_pending"}, max_out <= MAXP, max_out, MAXP);
    chk({nm, "_stall_hold_viol"}, stall_viol == 0, stall_viol, 0);
    @(negedge sdr_clk);
    chk({nm, "_readend_pulse"}, readend === 1'b0, readend, 0);
    chk({nm, "_busy_after"}, busy === 1'b0, busy, 0);
    repeat (3) @(negedge sdr_clk);
    chk_readdata({nm, "_readdata_hold"}, eb, exp_reads);
  endtask

  typedef struct {
    string       nm;
    logic [31:0] base;
    logic [29:0] ne;
    int          wp;
    int          lt;
    int          exp_reads;
    bit          exp_err;
    int          exp_end;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int n;
    logic [29:0] ne;
    int wp;
    int lt;
    logic [31:0] b;

    vecs[0] = '{"n15", 32'h0000_1000, 30'd15, 0, 1, 15, 1'b0, 17};
    vecs[1] = '{"n0", 32'h0000_2004, 30'd0, 0, 1, 0, 1'b0, 2};
    vecs[2] = '{"n100", 32'h0000_8000, 30'd100, 0, 1, 64, 1'b1, 66};
    vecs[3] = '{"wrap", 32'hFFFF_FFF3, 30'd6, 0, 1, 6, 1'b0, 8};
    vecs[4] = '{"stall64", 32'h0000_0040, 30'd64, 50, 5, 64, 1'b0, 0};
    vecs[5] = '{"n1", 32'h0000_0100, 30'd1, 0, 1, 1, 1'b0, 3};
    vecs[6] = '{"lat3_n64", 32'h00AB_0000, 30'd64, 0, 3, 64, 1'b0, 0};
    vecs[7] = '{"n65", 32'h0000_4000, 30'd65, 0, 1, 64, 1'b1, 66};

    sdr_reset = 1'b1;
    readstart = 1'b0;
    baseaddr = '0;
    nelems = '0;
    repeat (2) @(posedge sdr_clk);
    #1;
    chk_idle_outputs("reset");
    @(posedge sdr_clk); #1;
    sdr_reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].nm, vecs[i].base, vecs[i].ne, vecs[i].wp, vecs[i].lt,
              vecs[i].exp_reads, vecs[i].exp_err, vecs[i].exp_end);
      if (i == 2) chk("n100_word63", readdata[2047:2016] == mem(32'h0000_8000 + 32'd252),
                      readdata[2047:2016], mem(32'h0000_8000 + 32'd252));
    end

    // Re-pulse mid-transfer must be ignored; reset at word 7 aborts everything.
    wait_pct = 0;
    lat = 2;
    acc_q.delete();
    valids = 0;
    @(posedge sdr_clk); #1;
    readstart = 1'b1; baseaddr = 32'h0000_3000; nelems = 30'd20;
    @(posedge sdr_clk); #1;
    readstart = 1'b0;
    repeat (3) @(posedge sdr_clk);
    #1;
    readstart = 1'b1; baseaddr = 32'h0000_9000; nelems = 30'd5;
    @(posedge sdr_clk); #1;
    readstart = 1'b0;
    @(negedge sdr_clk);
    chk("repulse_busy", busy === 1'b1, busy, 1);
    chk("repulse_addr_region", avm_address[31:8] == 24'h000030, avm_address, 32'h0000_3000);
    for (int k = 0; k < 200; k++) begin
      if (valids >= 7) break;
      @(negedge sdr_clk);
    end
    chk("word7_reached", valids >= 7, valids, 7);
    @(posedge sdr_clk); #1;
    chk("pre_reset_word6", readdata[32*6 +: 32] == mem(32'h0000_3018),
        readdata[32*6 +: 32], mem(32'h0000_3018));
    sdr_reset = 1'b1;
    #1;
    chk_idle_outputs("midreset");
    repeat (2) @(posedge sdr_clk);
    #1;
    sdr_reset = 1'b0;
    stray_req = 1;
    repeat (8) @(negedge sdr_clk);
    chk("stray_readdata_nz", nz_words() == 0, nz_words(), 0);
    chk("stray_busy", busy === 1'b0, busy, 0);
    run_txn("after_reset", 32'h0000_0500, 30'd3, 0, 1, 3, 1'b0, 5);

    // Randomized requests checked against the word-level model.
    for (int r = 0; r < 12; r++) begin
      b = $urandom;
      ne = 30'($urandom_range(80));
      wp = $urandom_range(60);
      lt = $urandom_range(6, 1);
      n = (int'(ne) > MAXW) ? MAXW : int'(ne);
      run_txn($sformatf("rnd%0d", r), b, ne, wp, lt, n, int'(ne) > MAXW,
              (wp == 0 && lt == 1) ? n + 2 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
